// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry valid/ready holding register and error pulses.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 vote around each bit centre.
module uart_rx #(
    parameter int UART_CLOCK_HZ = 25_200_000,
    parameter int UART_BAUD     = 115_200
) (
    input  logic       clk_cpu,
    input  logic       n_reset,
    input  logic       uart_rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    localparam int CLKS_PER_BIT = UART_CLOCK_HZ / UART_BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta, rx_s, bit_val, done, bad;
    logic [2:0]    state, idx;
    logic [CW-1:0] cnt;
    logic [7:0]    shift;

    always_ff @(posedge clk_cpu or negedge n_reset)
        if (!n_reset) {rx_s, rx_meta} <= 2'b11;
        else          {rx_s, rx_meta} <= {rx_meta, uart_rx_pin};

`ifdef UART_RX_MAJORITY_EN
    // Decision lands one clock after centre so the vote sees centre-1, centre, centre+1.
    localparam logic [CW-1:0] START_END = CW'(HALF_BIT);
    logic [1:0] hist;
    always_ff @(posedge clk_cpu or negedge n_reset)
        if (!n_reset) hist <= 2'b11;
        else          hist <= {hist[0], rx_s};
    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    localparam logic [CW-1:0] START_END = CW'(HALF_BIT - 1);
    assign bit_val = rx_s;
`endif

    assign rx_busy = state != IDLE;

    always_ff @(posedge clk_cpu or negedge n_reset)
        if (!n_reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            done  <= 1'b0;
            bad   <= 1'b0;
        end else begin
            done <= 1'b0;
            bad  <= 1'b0;
            cnt  <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: if (cnt == START_END) begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= bit_val ? IDLE : DATA;
                end
                DATA: if (cnt == BIT_END) begin
                    cnt   <= '0;
                    shift <= {bit_val, shift[7:1]};
                    idx   <= idx + 3'd1;
                    if (idx == 3'd7) state <= STOP;
                end
                STOP: if (cnt == BIT_END) begin
                    cnt   <= '0;
                    state <= bit_val ? IDLE : BREAK;
                    done  <= bit_val;
                    bad   <= !bit_val;
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end

    // done and bad are exclusive, so frame_err and overrun can never coincide.
    always_ff @(posedge clk_cpu or negedge n_reset)
        if (!n_reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad;
            overrun   <= done && rx_valid && !rx_ready;
            if (done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the SoC peripheral bus; the receive counterpart of the existing UART Tx path.
- Samples the asynchronous `uart_rx_pin` in the CPU clock domain and deframes 8N1 characters, LSB first.
- Presents each byte through a one-entry holding register with a valid/ready handshake.
- Reports framing and overrun errors as single-cycle pulses for the SoC status register.

Parameters:
- UART_CLOCK_HZ, 25_200_000, frequency of `clk_cpu` in Hz.
- UART_BAUD, 115_200, line bit rate.
- CLKS_PER_BIT, UART_CLOCK_HZ/UART_BAUD (218 at defaults, integer truncation), bit period in clocks; localparam.
- HALF_BIT, CLKS_PER_BIT/2 (109 at defaults), offset to bit centre; localparam.

Ports:
- clk_cpu  input  1  single clock, rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- uart_rx_pin  input  1  asynchronous serial line, idles high.
- rx_data  output  8  received byte; valid while `rx_valid` is 1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts the byte when `rx_valid && rx_ready`.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte dropped because the holding register was full.
- rx_busy  output  1  1 whenever state is not IDLE.

Behaviour:
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0.
- Reset state: state=IDLE, bit counter=0, shift register=0, both synchroniser flops=1.
- Reset is asynchronous. Asserting it mid-frame aborts the frame; no partial byte is ever delivered.
- Input path: 2-flop synchroniser, `rx_s`. All decisions use `rx_s` only.
- Clock counter width: $clog2(CLKS_PER_BIT). The counter clears on every state transition.
- IDLE: when `rx_s`=0, go to START with counter=0.
- START: at counter=HALF_BIT-1, sample `rx_s`.
  - 1 → glitch; return to IDLE with no flags.
  - 0 → go to DATA with counter=0 and bit index=0.
- DATA: each time counter=CLKS_PER_BIT-1, sample `rx_s` into the shift register MSB and shift right.
  - The bit index increments per sample.
  - After index 7 is sampled, go to STOP.
- STOP: at counter=CLKS_PER_BIT-1, sample `rx_s`.
  - 1 → deliver the byte and go to IDLE.
  - 0 → pulse `frame_err` the next cycle, discard the byte, go to BREAK.
- BREAK: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line being decoded as repeated 0x00 bytes.
- Timing: the stop sample occurs HALF_BIT + 9*CLKS_PER_BIT clocks after IDLE sees `rx_s`=0. `rx_valid` and `rx_data` update on the following clock edge.
- Delivery rules:
  - `rx_valid`=0 → load `rx_data` and set `rx_valid`.
  - `rx_valid`=1 and `rx_ready`=1 in the same cycle → old byte consumed, new byte loaded, `rx_valid` stays 1, no overrun.
  - `rx_valid`=1 and `rx_ready`=0 → keep the old byte and pulse `overrun` for 1 cycle.
- Handshake: `rx_valid` clears the cycle after `rx_valid && rx_ready` unless a delivery coincides. `rx_data` is stable while `rx_valid`=1 and is not cleared on consume.
- `frame_err` and `overrun` never assert in the same cycle. A frame error suppresses delivery.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Enabled:
  - Every sample point (start, data, stop) takes a 2-of-3 majority of `rx_s` at counter values centre-1, centre, centre+1.
  - The decision is taken at centre+1, so all sample events shift one clock later.
  - The start-glitch check also uses the majority vote.
- Disabled: single sample at centre, as described in Behaviour; the vote registers are not instantiated.

Test Plan:
- Drive 0x55 8N1 at 115200 with `rx_ready`=1.
  - `rx_valid` pulses 1 cycle with `rx_data`=0x55.
  - `rx_valid` rises 109+9*218+1 clocks after `rx_s` falls (+1 with majority).
  - `frame_err`=0, `overrun`=0.
- Low glitch of 50 clocks on `uart_rx_pin`, line otherwise idle → state returns to IDLE, `rx_valid` never set, no error pulse.
- Send 0xA3 with the stop bit driven low, then hold the line low for 3 bit times, then high.
  - One `frame_err` pulse, no `rx_valid`.
  - `rx_busy` stays 1 until the line returns high.
  - A following 0x3C is received correctly.
- Send 0x12 then 0x34 back-to-back with `rx_ready`=0.
  - `rx_data`=0x12 held, one `overrun` pulse.
  - Asserting `rx_ready` then clears `rx_valid`.
- With 0x12 pending, assert `rx_ready` exactly in 0x34's delivery cycle → `rx_data`=0x34, `rx_valid` stays 1, no `overrun`.
- Assert `n_reset`=0 midway through data bit 4 of 0xFF.
  - All outputs return to reset values immediately.
  - After release with the line idle, no byte is delivered.
  - The next full frame (0x81) is received correctly.
